// File: rtl/sensor_frame_serializer.sv
// Snapshots a packed bus of sensor words on a start event and streams it as a
// framed byte sequence (sync, payload, XOR checksum) over valid/ready.
module sensor_frame_serializer #(
  parameter int         NUM_SENSORS   = 8,
  parameter int         SENSOR_WIDTH  = 32,  // multiple of 8
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         PERIOD_CYCLES = 500000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_SENSORS*SENSOR_WIDTH-1:0] data,
  input  logic                                trigger,
  output logic [7:0]                          tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                busy,
  output logic [15:0]                         frame_count,
  output logic [7:0]                          overrun_count
);

  localparam int BUS_W     = NUM_SENSORS * SENSOR_WIDTH;
  localparam int NUM_BYTES = BUS_W / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHECK} state_t;

  state_t           state;
  logic [BUS_W-1:0] snapshot;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] next_idx;
  logic [7:0]       checksum;
  logic             tick;
  logic             start;
  logic             handshake;
  logic [7:0]       snap_bytes [NUM_BYTES];

  // Byte k of the frame payload is bits [8k+7:8k] of the snapshot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign snap_bytes[gi] = snapshot[8*gi +: 8];
    end
  endgenerate

  generate
    if (PERIOD_CYCLES > 0) begin : g_timer
      localparam int TMR_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
      localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CYCLES - 1);
      logic [TMR_W-1:0] timer;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          timer <= '0;
        end else if (timer == TMR_LAST) begin
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      // Asserted in the cycle whose closing edge wraps the counter to 0.
      assign tick = (timer == TMR_LAST);
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  assign start     = trigger | tick;
  assign handshake = tx_valid & tx_ready;
  assign next_idx  = byte_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      snapshot      <= '0;
      byte_idx      <= '0;
      checksum      <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      // Start requests arriving mid-frame, including the final handshake cycle, are dropped.
      if (start && busy && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= data;
            byte_idx <= '0;
            checksum <= '0;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SYNC;
          end
        end

        SYNC: begin
          if (handshake) begin
            tx_data <= snap_bytes[0];
            state   <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (handshake) begin
            checksum <= checksum ^ tx_data;
            if (byte_idx == LAST_IDX) begin
              tx_data <= checksum ^ tx_data;
              state   <= CHECK;
            end else begin
              tx_data  <= snap_bytes[next_idx];
              byte_idx <= next_idx;
            end
          end
        end

        CHECK: begin
          if (handshake) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= frame_count + 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
